latch_chain_bist_ctrl: RTL

LATCH_CHAIN_BIST_CTRL -- requirements
Module: latch_chain_bist_ctrl

---
 rtl/latch_chain_bist_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/latch_chain_bist_ctrl.sv
// BIST controller for a two-phase latch chain: drives non-overlapping ph1/ph2,
// shifts a test pattern in and compares the delayed stream coming back out.
module latch_chain_bist_ctrl #(
   parameter int CHAIN_LEN = 128,
   parameter int GAP       = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [1:0]  mode,
   input  logic [7:0]  seed,
   input  logic [15:0] nbits,
   input  logic        sr_out,
   output logic        ph1,
   output logic        ph2,
   output logic        sr_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count
);
   localparam int STEP = 2 + 2*GAP;
   localparam int HALF = CHAIN_LEN/2;
   localparam int D    = HALF - 1;
   localparam int CW   = $clog2(STEP);
   localparam logic [CW-1:0] CYC_LAST = CW'(STEP-1);
   localparam logic [CW-1:0] CYC_PH2  = CW'(GAP+1);

   typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cyc;
   logic [16:0]   step_cnt, cmp_cnt, exp_idx;
   logic [1:0]    mode_q;
   logic [15:0]   nbits_q, err_nx;
   logic [7:0]    drv_lfsr, exp_lfsr;
   logic          active, step_end, cmp_en, exp_act, exp_bit, mism;

   function automatic logic [7:0] lfsr_next(input logic [7:0] lf);
      return {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
   endfunction

   function automatic logic pat_bit(input logic [1:0] m, input logic [7:0] lf,
                                    input logic [16:0] idx);
      case (m)
         2'd0:    pat_bit = lf[7];
         2'd1:    pat_bit = ~idx[0];
         2'd2:    pat_bit = 1'b1;
         default: pat_bit = (idx == '0);
      endcase
   endfunction

   assign active   = (state == FLUSH) || (state == RUN) || (state == DRAIN);
   assign step_end = active && (cyc == CYC_LAST);

   // The expected generator lags the driver by the chain delay; before it starts
   // the chain still holds flush zeros.
   assign exp_act = (cmp_cnt >= 17'(D));
   assign exp_idx = cmp_cnt - 17'(D);
   assign exp_bit = exp_act && pat_bit(mode_q, exp_lfsr, exp_idx);
   assign cmp_en  = step_end && !abort && ((state == RUN) || (state == DRAIN));
   assign mism    = cmp_en && (sr_out != exp_bit);
   assign err_nx  = (mism && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

   always_comb begin
      state_nx = state;
      ph1      = 1'b0;
      ph2      = 1'b0;
      sr_in    = 1'b0;
      busy     = (state != IDLE);
      done     = (state == DONE);
      case (state)
         IDLE:  if (start) state_nx = FLUSH;
         FLUSH: begin
            if (abort) state_nx = DONE;
            else if (step_end && step_cnt == 17'(HALF-1))
               state_nx = (nbits_q == '0) ? DRAIN : RUN;
         end
         RUN: begin
            sr_in = pat_bit(mode_q, drv_lfsr, step_cnt);
            if (abort) state_nx = DONE;
            else if (step_end && step_cnt == {1'b0, nbits_q} - 17'd1) state_nx = DRAIN;
         end
         DRAIN: begin
            if (abort) state_nx = DONE;
            else if (step_end && step_cnt == 17'(D-1)) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (active && !(state == RUN && abort)) begin
         ph1 = (cyc == '0);
         ph2 = (cyc == CYC_PH2);
      end
      if (!active) sr_in = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cyc       <= '0;
         step_cnt  <= '0;
         cmp_cnt   <= '0;
         mode_q    <= '0;
         nbits_q   <= '0;
         drv_lfsr  <= 8'h01;
         exp_lfsr  <= 8'h01;
         err_count <= '0;
         pass      <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE) begin
            cyc      <= '0;
            step_cnt <= '0;
            cmp_cnt  <= '0;
            if (start) begin
               mode_q    <= mode;
               nbits_q   <= nbits;
               drv_lfsr  <= (seed == '0) ? 8'h01 : seed;
               exp_lfsr  <= (seed == '0) ? 8'h01 : seed;
               err_count <= '0;
               pass      <= 1'b0;
            end
         end else begin
            if (state_nx != state) begin
               cyc      <= '0;
               step_cnt <= '0;
            end else if (step_end) begin
               cyc      <= '0;
               step_cnt <= step_cnt + 17'd1;
            end else begin
               cyc <= cyc + CW'(1);
            end
            if (state == RUN && step_end) drv_lfsr <= lfsr_next(drv_lfsr);
            if (cmp_en) begin
               cmp_cnt <= cmp_cnt + 17'd1;
               if (exp_act) exp_lfsr <= lfsr_next(exp_lfsr);
            end
            err_count <= err_nx;
            // pass is settled on the edge into DONE so it is valid alongside done
            if (state_nx == DONE && state != DONE) pass <= !abort && (err_nx == '0);
            if (state == DONE && abort) pass <= 1'b0;
         end
      end
   end
endmodule
